// File: rtl/apex20ke_bidir_turnaround_ctrl_pkg.sv
// rtl/apex20ke_bidir_turnaround_ctrl_pkg.sv - shared state encodings and counter widths
package apex20ke_bidir_turnaround_ctrl_pkg;

   localparam int TURN_W  = 4;
   localparam int BURST_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TA_DRV = 2'd1,
      ST_DRIVE  = 2'd2,
      ST_TA_REL = 2'd3
   } state_t;

endpackage

// File: rtl/apex20ke_bidir_turnaround_ctrl_if.sv
// rtl/apex20ke_bidir_turnaround_ctrl_if.sv - local stream, pad atom and status signals of the controller
interface apex20ke_bidir_turnaround_ctrl_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             remote_busy;
   logic [WIDTH-1:0] pad_datain;
   logic             pad_oe;
   logic [WIDTH-1:0] pad_combout;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             collision;
   logic             busy;

   modport slave (
      input  tx_data, tx_valid, remote_busy, pad_combout,
      output tx_ready, pad_datain, pad_oe, rx_data, rx_valid, collision, busy
   );

   modport master (
      output tx_data, tx_valid, remote_busy, pad_combout,
      input  tx_ready, pad_datain, pad_oe, rx_data, rx_valid, collision, busy
   );

endinterface

// File: rtl/apex20ke_turn_counter.sv
// rtl/apex20ke_turn_counter.sv - loadable down counter with zero flag, shared by both turnaround states
module apex20ke_turn_counter
   import apex20ke_bidir_turnaround_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [TURN_W-1:0] i_load_val,
   input  logic              i_dec,
   output logic [TURN_W-1:0] o_count,
   output logic              o_zero
);

   logic [TURN_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/apex20ke_bidir_turnaround_ctrl.sv
// rtl/apex20ke_bidir_turnaround_ctrl.sv - half-duplex bidir pad owner with turnaround guards and burst limit
module apex20ke_bidir_turnaround_ctrl
   import apex20ke_bidir_turnaround_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,
   parameter int MAX_BURST   = 16
) (
   input  logic clk,
   input  logic reset,
   apex20ke_bidir_turnaround_ctrl_if.slave bus
);

   localparam logic [TURN_W-1:0]  TURN_LOAD  = TURN_W'(TURN_CYCLES);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
   localparam logic [BURST_W-1:0] BURST_SAT  = BURST_W'(MAX_BURST);

   state_t             r_state;
   state_t             w_next;
   logic               w_load;
   logic               w_dec;
   logic               w_clr_burst;
   logic               w_tx_ready;
   logic               w_xfer;
   logic               w_turn_last;
   logic [TURN_W-1:0]  w_count;
   logic               w_zero;
   logic [BURST_W-1:0] r_burst;
   logic [WIDTH-1:0]   r_pad_datain;
   logic               r_pad_oe;
   logic [WIDTH-1:0]   r_rx_data;
   logic               r_rx_valid;
   logic               r_collision;
   logic               r_busy;

   apex20ke_turn_counter u_turn (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (TURN_LOAD),
      .i_dec      (w_dec),
      .o_count    (w_count),
      .o_zero     (w_zero)
   );

   // The guard ends on the cycle whose decrement takes the counter to zero.
   assign w_turn_last = w_zero || (w_count == TURN_W'(1));
   assign w_xfer      = bus.tx_valid && w_tx_ready;

   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_clr_burst = 1'b0;
      w_tx_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!bus.remote_busy && bus.tx_valid) begin
               w_next = ST_TA_DRV;
               w_load = 1'b1;
            end
         end
         ST_TA_DRV: begin
            if (bus.remote_busy) begin
               w_next = ST_IDLE;
            end else begin
               w_dec = 1'b1;
               if (w_turn_last) begin
                  w_next      = ST_DRIVE;
                  w_clr_burst = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            w_tx_ready = !bus.remote_busy;
            if (bus.remote_busy || !bus.tx_valid || (r_burst == BURST_LAST)) begin
               w_next = ST_TA_REL;
               w_load = 1'b1;
            end
         end
         ST_TA_REL: begin
            w_dec = 1'b1;
            if (w_turn_last) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_burst      <= '0;
         r_pad_datain <= '0;
         r_pad_oe     <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_collision  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != ST_IDLE);

         // Word is presented on the pads the cycle after it is accepted.
         if (w_xfer) begin
            r_pad_datain <= bus.tx_data;
            r_pad_oe     <= 1'b1;
         end else begin
            r_pad_oe     <= 1'b0;
         end

         if (w_clr_burst) begin
            r_burst <= '0;
         end else if (w_xfer && (r_burst != BURST_SAT)) begin
            r_burst <= r_burst + 1'b1;
         end

         if ((r_state == ST_DRIVE) && bus.remote_busy) begin
            r_collision <= 1'b1;
         end

         if ((r_state == ST_IDLE) && bus.remote_busy) begin
            r_rx_data  <= bus.pad_combout;
            r_rx_valid <= 1'b1;
         end else begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign bus.tx_ready   = w_tx_ready;
   assign bus.pad_datain = r_pad_datain;
   assign bus.pad_oe     = r_pad_oe;
   assign bus.rx_data    = r_rx_data;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.collision  = r_collision;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_apex20ke_bidir_turnaround_ctrl.sv
// tb/tb_apex20ke_bidir_turnaround_ctrl.sv - directed self-checking bench for the turnaround controller
module tb_apex20ke_bidir_turnaround_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   apex20ke_bidir_turnaround_ctrl_if #(.WIDTH(8)) bus ();

   apex20ke_bidir_turnaround_ctrl #(
      .WIDTH       (8),
      .TURN_CYCLES (2),
      .MAX_BURST   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin : main
      logic [7:0] words [6];
      logic [7:0] seen  [6];
      int         idx;
      int         n_hi;
      int         gap;
      logic       in_gap;
      logic       saw_idle;
      logic       acc;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.tx_data     = '0;
      bus.tx_valid    = 1'b0;
      bus.remote_busy = 1'b0;
      bus.pad_combout = '0;

      // Reset state
      tick();
      tick();
      chk("rst_oe",        32'(bus.pad_oe),     32'd0);
      chk("rst_datain",    32'(bus.pad_datain), 32'h00);
      chk("rst_rx_valid",  32'(bus.rx_valid),   32'd0);
      chk("rst_rx_data",   32'(bus.rx_data),    32'h00);
      chk("rst_collision", 32'(bus.collision),  32'd0);
      chk("rst_busy",      32'(bus.busy),       32'd0);
      chk("rst_tx_ready",  32'(bus.tx_ready),   32'd0);
      reset = 1'b0;

      // Quiet idle
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_oe",       32'(bus.pad_oe),   32'd0);
         chk("idle_busy",     32'(bus.busy),     32'd0);
         chk("idle_rx_valid", 32'(bus.rx_valid), 32'd0);
      end

      // Three-word burst
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h11;
      #1;
      chk("b3_idle_ready", 32'(bus.tx_ready), 32'd0);
      tick();
      chk("b3_tad1_busy",  32'(bus.busy),     32'd1);
      chk("b3_tad1_oe",    32'(bus.pad_oe),   32'd0);
      chk("b3_tad1_ready", 32'(bus.tx_ready), 32'd0);
      tick();
      chk("b3_tad2_oe",    32'(bus.pad_oe),   32'd0);
      chk("b3_tad2_ready", 32'(bus.tx_ready), 32'd0);
      tick();
      chk("b3_drv_ready",  32'(bus.tx_ready), 32'd1);
      chk("b3_drv_oe",     32'(bus.pad_oe),   32'd0);
      tick();
      chk("b3_w1_oe",      32'(bus.pad_oe),     32'd1);
      chk("b3_w1_data",    32'(bus.pad_datain), 32'h11);
      bus.tx_data = 8'h22;
      tick();
      chk("b3_w2_oe",      32'(bus.pad_oe),     32'd1);
      chk("b3_w2_data",    32'(bus.pad_datain), 32'h22);
      bus.tx_data = 8'h33;
      tick();
      chk("b3_w3_oe",      32'(bus.pad_oe),     32'd1);
      chk("b3_w3_data",    32'(bus.pad_datain), 32'h33);
      bus.tx_valid = 1'b0;
      tick();
      chk("b3_rel1_oe",    32'(bus.pad_oe),     32'd0);
      chk("b3_rel1_hold",  32'(bus.pad_datain), 32'h33);
      chk("b3_rel1_busy",  32'(bus.busy),       32'd1);
      tick();
      chk("b3_rel2_oe",    32'(bus.pad_oe),     32'd0);
      chk("b3_rel2_busy",  32'(bus.busy),       32'd1);
      tick();
      chk("b3_idle_busy",  32'(bus.busy),       32'd0);
      chk("b3_idle_oe",    32'(bus.pad_oe),     32'd0);

      // Six words against a burst limit of four
      for (int i = 0; i < 6; i++) words[i] = 8'(8'h01 + i);
      idx = 0; n_hi = 0; gap = 0; in_gap = 1'b0; saw_idle = 1'b0;
      bus.tx_valid = 1'b1;
      bus.tx_data  = words[0];
      for (int c = 0; c < 30; c++) begin
         #1;
         acc = bus.tx_valid && bus.tx_ready;
         tick();
         if (acc) begin
            idx++;
            if (idx >= 6) bus.tx_valid = 1'b0;
            else          bus.tx_data  = words[idx];
         end
         if (bus.pad_oe) begin
            if (n_hi < 6) seen[n_hi] = bus.pad_datain;
            n_hi++;
            in_gap = 1'b0;
         end else if (n_hi == 4) begin
            in_gap = 1'b1;
            gap++;
            if (!bus.busy) saw_idle = 1'b1;
         end
      end
      chk("mb_oe_cycles", 32'(n_hi), 32'd6);
      chk("mb_gap",       32'(gap),  32'd5);
      chk("mb_saw_idle",  32'(saw_idle), 32'd1);
      for (int i = 0; i < 6; i++) chk("mb_word", 32'(seen[i]), 32'(words[i]));
      chk("mb_end_busy",  32'(bus.busy), 32'd0);

      // Peer receive, remote wins over local request
      bus.remote_busy = 1'b1;
      bus.pad_combout = 8'hA5;
      bus.tx_valid    = 1'b1;
      bus.tx_data     = 8'h77;
      #1;
      chk("rx_held_ready", 32'(bus.tx_ready), 32'd0);
      tick();
      chk("rx1_data",  32'(bus.rx_data),  32'hA5);
      chk("rx1_valid", 32'(bus.rx_valid), 32'd1);
      chk("rx1_busy",  32'(bus.busy),     32'd0);
      chk("rx1_oe",    32'(bus.pad_oe),   32'd0);
      bus.pad_combout = 8'h5A;
      tick();
      chk("rx2_data",  32'(bus.rx_data),  32'h5A);
      chk("rx2_valid", 32'(bus.rx_valid), 32'd1);
      bus.remote_busy = 1'b0;
      bus.tx_valid    = 1'b0;
      tick();
      chk("rx3_valid", 32'(bus.rx_valid), 32'd0);
      chk("rx3_hold",  32'(bus.rx_data),  32'h5A);

      // Back-off during drive turnaround
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h44;
      tick();
      chk("bo_tad_busy", 32'(bus.busy), 32'd1);
      bus.remote_busy = 1'b1;
      tick();
      chk("bo_busy",      32'(bus.busy),      32'd0);
      chk("bo_collision", 32'(bus.collision), 32'd0);
      chk("bo_rx_valid",  32'(bus.rx_valid),  32'd0);
      bus.remote_busy = 1'b0;
      bus.tx_valid    = 1'b0;
      tick();

      // Collision after two driven words
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h81;
      tick();
      tick();
      tick();
      tick();
      chk("col_w1_data", 32'(bus.pad_datain), 32'h81);
      bus.tx_data = 8'h82;
      tick();
      chk("col_w2_oe",   32'(bus.pad_oe),     32'd1);
      chk("col_w2_data", 32'(bus.pad_datain), 32'h82);
      bus.tx_data     = 8'h83;
      bus.remote_busy = 1'b1;
      #1;
      chk("col_ready", 32'(bus.tx_ready), 32'd0);
      tick();
      chk("col_flag",     32'(bus.collision),  32'd1);
      chk("col_oe",       32'(bus.pad_oe),     32'd0);
      chk("col_hold",     32'(bus.pad_datain), 32'h82);
      chk("col_rel_busy", 32'(bus.busy),       32'd1);
      bus.remote_busy = 1'b0;
      bus.tx_valid    = 1'b0;
      tick();
      chk("col_rel2_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("col_idle_busy", 32'(bus.busy),      32'd0);
      chk("col_sticky1",   32'(bus.collision), 32'd1);
      tick();
      tick();
      chk("col_sticky2",   32'(bus.collision), 32'd1);

      // Reset in the middle of a burst
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h91;
      tick();
      tick();
      tick();
      tick();
      chk("mr_oe_before", 32'(bus.pad_oe), 32'd1);
      reset = 1'b1;
      tick();
      chk("mr_oe",        32'(bus.pad_oe),     32'd0);
      chk("mr_busy",      32'(bus.busy),       32'd0);
      chk("mr_collision", 32'(bus.collision),  32'd0);
      chk("mr_datain",    32'(bus.pad_datain), 32'h00);
      chk("mr_ready",     32'(bus.tx_ready),   32'd0);
      reset        = 1'b0;
      bus.tx_valid = 1'b0;
      tick();
      chk("mr_after_busy",  32'(bus.busy),     32'd0);
      chk("mr_after_ready", 32'(bus.tx_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
